hazard_unit: RTL and testbench

//  Hazard/forwarding controller for the 5-stage MIPS pipeline; partner of the datapath's hazard-control interface.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_unit_if.sv | 51 +++++
 rtl/hazard_mult_tracker.sv | 64 ++++++
 rtl/hazard_unit.sv | 103 ++++++++++
 tb/tb_hazard_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: writeback sources,
// forward-mux selects, branch kinds and multiplier-tracker states.
package hazard_pkg;

  localparam logic [2:0] WB_ALU  = 3'b000;
  localparam logic [2:0] WB_MEM  = 3'b001;
  localparam logic [2:0] WB_PC8  = 3'b010;
  localparam logic [2:0] WB_MFHI = 3'b011;
  localparam logic [2:0] WB_MFLO = 3'b100;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  typedef enum logic [0:0] {
    MULT_IDLE = 1'b0,
    MULT_BUSY = 1'b1
  } multState_e;

  // $0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic regMatch(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-control bundle between the 5-stage datapath (master) and the
// hazard unit (slave).
interface hazard_unit_if;

  logic [4:0] RsD;
  logic [4:0] RtD;
  logic [1:0] branchD;
  logic [2:0] WBSrcD;
  logic       MultStartD;

  logic [4:0] RsE;
  logic [4:0] RtE;
  logic [4:0] WriteRegE;
  logic       RegWriteE;
  logic [2:0] WBSrcE;
  logic       MultStartE;
  logic       MultDoneE;

  logic [4:0] WriteRegM;
  logic       RegWriteM;
  logic [2:0] WBSrcM;

  logic [4:0] WriteRegW;
  logic       RegWriteW;

  logic       stallF;
  logic       stallD;
  logic       flushE;
  logic       forwardAD;
  logic       forwardBD;
  logic [1:0] forwardAE;
  logic [1:0] forwardBE;
  logic       mult_err;

  modport master (
    output RsD, RtD, branchD, WBSrcD, MultStartD,
    output RsE, RtE, WriteRegE, RegWriteE, WBSrcE, MultStartE, MultDoneE,
    output WriteRegM, RegWriteM, WBSrcM,
    output WriteRegW, RegWriteW,
    input  stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE, mult_err
  );

  modport slave (
    input  RsD, RtD, branchD, WBSrcD, MultStartD,
    input  RsE, RtE, WriteRegE, RegWriteE, WBSrcE, MultStartE, MultDoneE,
    input  WriteRegM, RegWriteM, WBSrcM,
    input  WriteRegW, RegWriteW,
    output stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE, mult_err
  );

endinterface

// File: rtl/hazard_mult_tracker.sv
// Multi-cycle multiplier tracker: IDLE/BUSY FSM with a watchdog that aborts a
// multiply that never reports done and latches a sticky error.
module hazard_mult_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic multStartE,
  input  logic multDoneE,
  output logic multBusy,
  output logic multErr
);

  localparam logic [0:0] S_IDLE   = MULT_IDLE;
  localparam logic [0:0] S_BUSY   = MULT_BUSY;
  localparam logic [7:0] CNT_LAST = 8'(MULT_TIMEOUT - 1);

  if ((MULT_TIMEOUT < 2) || (MULT_TIMEOUT > 255)) begin : gBadTimeout
    $error("hazard_mult_tracker: MULT_TIMEOUT must be in 2..255");
  end

  logic [0:0] state;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      multErr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A stray done with no multiply in flight is ignored.
          if (multStartE) begin
            state <= S_BUSY;
            cnt   <= '0;
          end
        end
        S_BUSY: begin
          if (multDoneE) begin
            // Done coinciding with a new launch chains straight into the next multiply.
            if (!multStartE) state <= S_IDLE;
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            multErr <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign multBusy = (state == S_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_unit_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] lw_stall_cnt,
  output logic [CNT_W-1:0] br_stall_cnt,
  output logic [CNT_W-1:0] mult_stall_cnt
`endif
);

  if (CNT_W < 1) begin : gBadCntW
    $error("hazard_unit: CNT_W must be at least 1");
  end

  logic       multBusy;
  logic       lwStall;
  logic       brStall;
  logic       multStall;
  logic       stall;
  logic       fwdAD;
  logic       fwdBD;
  logic [1:0] fwdAE;
  logic [1:0] fwdBE;

  hazard_mult_tracker #(
    .MULT_TIMEOUT (MULT_TIMEOUT)
  ) u_multTracker (
    .clk        (clk),
    .rst        (rst),
    .multStartE (hz.MultStartE),
    .multDoneE  (hz.MultDoneE),
    .multBusy   (multBusy),
    .multErr    (hz.mult_err)
  );

  always_comb begin
    lwStall = (hz.WBSrcE == WB_MEM) &&
              (regMatch(hz.RtE, hz.RsD) || regMatch(hz.RtE, hz.RtD));

    // Branches resolve in decode, so an ALU result still in E or a load in M cannot be forwarded yet.
    brStall = (hz.branchD != BR_NONE) &&
              ((hz.RegWriteE &&
                (regMatch(hz.WriteRegE, hz.RsD) || regMatch(hz.WriteRegE, hz.RtD))) ||
               ((hz.WBSrcM == WB_MEM) &&
                (regMatch(hz.WriteRegM, hz.RsD) || regMatch(hz.WriteRegM, hz.RtD))));

    multStall = multBusy &&
                ((hz.WBSrcD == WB_MFHI) || (hz.WBSrcD == WB_MFLO) || hz.MultStartD);

    stall = lwStall | brStall | multStall;
  end

  always_comb begin
    fwdAD = hz.RegWriteM && regMatch(hz.WriteRegM, hz.RsD);
    fwdBD = hz.RegWriteM && regMatch(hz.WriteRegM, hz.RtD);

    // The memory stage holds the younger value, so it wins over writeback.
    fwdAE = FWD_RF;
    if (hz.RegWriteM && regMatch(hz.WriteRegM, hz.RsE))      fwdAE = FWD_M;
    else if (hz.RegWriteW && regMatch(hz.WriteRegW, hz.RsE)) fwdAE = FWD_W;

    fwdBE = FWD_RF;
    if (hz.RegWriteM && regMatch(hz.WriteRegM, hz.RtE))      fwdBE = FWD_M;
    else if (hz.RegWriteW && regMatch(hz.WriteRegW, hz.RtE)) fwdBE = FWD_W;
  end

  // Reset holds the pipeline flowing with bubbles injected into execute.
  assign hz.stallF    = stall & ~rst;
  assign hz.stallD    = stall & ~rst;
  assign hz.flushE    = stall | rst;
  assign hz.forwardAD = fwdAD & ~rst;
  assign hz.forwardBD = fwdBD & ~rst;
  assign hz.forwardAE = rst ? FWD_RF : fwdAE;
  assign hz.forwardBE = rst ? FWD_RF : fwdBE;

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      lw_stall_cnt   <= '0;
      br_stall_cnt   <= '0;
      mult_stall_cnt <= '0;
    end else begin
      if (lwStall)   lw_stall_cnt   <= satInc(lw_stall_cnt);
      if (brStall)   br_stall_cnt   <= satInc(br_stall_cnt);
      if (multStall) mult_stall_cnt <= satInc(mult_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// traffic compared against a behavioural model of the hazard rules.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_if hif();

  hazard_unit #(
    .MULT_TIMEOUT (TO),
    .CNT_W        (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  int passCnt  = 0;
  int totalCnt = 0;

  // Model of the multiplier: in flight or not, cycles spent waiting, sticky error.
  bit mInFlight = 1'b0;
  int mWaited   = 0;
  bit mErr      = 1'b0;

  function automatic bit dep(logic [4:0] dst, logic [4:0] src);
    return (dst != 0) && (dst == src);
  endfunction

  // {stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE, mult_err}
  function automatic logic [9:0] expected();
    bit lw, br, mu, s;
    logic [1:0] ae, be;
    if (rst) return {3'b001, 2'b00, 2'b00, 2'b00, mErr};
    lw = (hif.WBSrcE == 3'd1) && (dep(hif.RtE, hif.RsD) || dep(hif.RtE, hif.RtD));
    br = (hif.branchD != 0) &&
         ((hif.RegWriteE && (dep(hif.WriteRegE, hif.RsD) || dep(hif.WriteRegE, hif.RtD))) ||
          (hif.WBSrcM == 3'd1 && (dep(hif.WriteRegM, hif.RsD) || dep(hif.WriteRegM, hif.RtD))));
    mu = mInFlight && (hif.WBSrcD == 3'd3 || hif.WBSrcD == 3'd4 || hif.MultStartD);
    s  = lw || br || mu;
    ae = (hif.RegWriteM && dep(hif.WriteRegM, hif.RsE)) ? 2'd2 :
         (hif.RegWriteW && dep(hif.WriteRegW, hif.RsE)) ? 2'd1 : 2'd0;
    be = (hif.RegWriteM && dep(hif.WriteRegM, hif.RtE)) ? 2'd2 :
         (hif.RegWriteW && dep(hif.WriteRegW, hif.RtE)) ? 2'd1 : 2'd0;
    return {s, s, s,
            hif.RegWriteM && dep(hif.WriteRegM, hif.RsD),
            hif.RegWriteM && dep(hif.WriteRegM, hif.RtD),
            ae, be, mErr};
  endfunction

  function automatic logic [9:0] observed();
    return {hif.stallF, hif.stallD, hif.flushE, hif.forwardAD, hif.forwardBD,
            hif.forwardAE, hif.forwardBE, hif.mult_err};
  endfunction

  // Advance one clock, moving the multiplier model with the inputs of the ending cycle.
  task automatic tick();
    bit nF = mInFlight;
    int nW = mWaited;
    bit nE = mErr;
    if (rst) begin
      nF = 0; nW = 0; nE = 0;
    end else if (!mInFlight) begin
      if (hif.MultStartE) begin nF = 1; nW = 0; end
    end else if (hif.MultDoneE) begin
      nF = hif.MultStartE; nW = 0;
    end else if (mWaited + 1 >= TO) begin
      nF = 0; nW = 0; nE = 1;
    end else begin
      nW = mWaited + 1;
    end
    @(posedge clk);
    mInFlight = nF; mWaited = nW; mErr = nE;
    #1;
  endtask

  task automatic clearIn();
    rst = 0;
    hif.RsD = 0; hif.RtD = 0; hif.branchD = 0; hif.WBSrcD = 0; hif.MultStartD = 0;
    hif.RsE = 0; hif.RtE = 0; hif.WriteRegE = 0; hif.RegWriteE = 0; hif.WBSrcE = 0;
    hif.MultStartE = 0; hif.MultDoneE = 0;
    hif.WriteRegM = 0; hif.RegWriteM = 0; hif.WBSrcM = 0;
    hif.WriteRegW = 0; hif.RegWriteW = 0;
  endtask

  task automatic randIn();
    hif.RsD = 5'($urandom_range(0, 3)); hif.RtD = 5'($urandom_range(0, 3));
    hif.branchD = 2'($urandom); hif.WBSrcD = 3'($urandom_range(0, 4));
    hif.MultStartD = 1'($urandom);
    hif.RsE = 5'($urandom_range(0, 3)); hif.RtE = 5'($urandom_range(0, 3));
    hif.WriteRegE = 5'($urandom_range(0, 3)); hif.RegWriteE = 1'($urandom);
    hif.WBSrcE = 3'($urandom_range(0, 4));
    hif.MultStartE = ($urandom_range(0, 7) == 0);
    hif.MultDoneE  = ($urandom_range(0, 5) == 0);
    hif.WriteRegM = 5'($urandom_range(0, 3)); hif.RegWriteM = 1'($urandom);
    hif.WBSrcM = 3'($urandom_range(0, 4));
    hif.WriteRegW = 5'($urandom_range(0, 3)); hif.RegWriteW = 1'($urandom);
  endtask

  task automatic test_reset();
    clearIn();
    randIn();
    rst = 1;
    @(negedge clk);
    totalCnt++;
    if (observed() >= 10'd0 && observed() >> 1 !== 10'b0010000000 >> 1)
      $display("FAIL reset_outputs got %b want 001000000x", observed());
    else passCnt++;
    tick();
    clearIn();
    @(negedge clk);
    totalCnt++;
    if (observed() !== 10'b0) $display("FAIL reset_release got %b want %b", observed(), 10'b0);
    else passCnt++;
    tick();
  endtask

  task automatic test_load_use();
    clearIn();
    hif.WBSrcE = WB_MEM; hif.RtE = 8; hif.RsD = 8;
    @(negedge clk);
    totalCnt++;
    if ({hif.stallF, hif.stallD, hif.flushE} !== 3'b111)
      $display("FAIL load_use got %b want 111", {hif.stallF, hif.stallD, hif.flushE});
    else passCnt++;
    tick();
    hif.WBSrcE = WB_ALU;
    @(negedge clk);
    totalCnt++;
    if ({hif.stallF, hif.stallD, hif.flushE} !== 3'b000)
      $display("FAIL load_use_clear got %b want 000", {hif.stallF, hif.stallD, hif.flushE});
    else passCnt++;
    tick();
    hif.WBSrcE = WB_MEM; hif.RtE = 0; hif.RsD = 0;
    @(negedge clk);
    totalCnt++;
    if (hif.stallF !== 1'b0) $display("FAIL load_use_r0 got %b want 0", hif.stallF);
    else passCnt++;
    tick();
  endtask

  task automatic test_forward_priority();
    clearIn();
    hif.RsE = 5; hif.RegWriteM = 1; hif.WriteRegM = 5; hif.RegWriteW = 1; hif.WriteRegW = 5;
    @(negedge clk);
    totalCnt++;
    if (hif.forwardAE !== 2'b10) $display("FAIL fwd_m_wins got %b want 10", hif.forwardAE);
    else passCnt++;
    tick();
    hif.RegWriteM = 0;
    @(negedge clk);
    totalCnt++;
    if (hif.forwardAE !== 2'b01) $display("FAIL fwd_w got %b want 01", hif.forwardAE);
    else passCnt++;
    tick();
    hif.RsE = 0; hif.WriteRegW = 0; hif.RtE = 5; hif.WriteRegM = 5; hif.RegWriteM = 1;
    @(negedge clk);
    totalCnt++;
    if ({hif.forwardAE, hif.forwardBE} !== 4'b0010)
      $display("FAIL fwd_r0_and_be got %b want 0010", {hif.forwardAE, hif.forwardBE});
    else passCnt++;
    tick();
  endtask

  task automatic test_branch();
    clearIn();
    hif.branchD = BR_BEQ; hif.RegWriteE = 1; hif.WriteRegE = 3; hif.RsD = 3;
    @(negedge clk);
    totalCnt++;
    if ({hif.stallF, hif.forwardAD} !== 2'b10)
      $display("FAIL branch_stall got %b want 10", {hif.stallF, hif.forwardAD});
    else passCnt++;
    tick();
    hif.RegWriteE = 0; hif.WriteRegE = 0;
    hif.WriteRegM = 3; hif.RegWriteM = 1; hif.WBSrcM = WB_ALU;
    @(negedge clk);
    totalCnt++;
    if ({hif.stallF, hif.flushE, hif.forwardAD} !== 3'b001)
      $display("FAIL branch_fwd got %b want 001", {hif.stallF, hif.flushE, hif.forwardAD});
    else passCnt++;
    tick();
    hif.WBSrcM = WB_MEM; hif.branchD = 2'b11;
    @(negedge clk);
    totalCnt++;
    if (hif.stallF !== 1'b1) $display("FAIL branch_load_m got %b want 1", hif.stallF);
    else passCnt++;
    tick();
  endtask

  task automatic test_mult();
    clearIn();
    hif.WBSrcD = WB_MFHI; hif.MultStartE = 1;
    @(negedge clk);
    totalCnt++;
    if (hif.stallF !== 1'b0) $display("FAIL mult_launch got %b want 0", hif.stallF);
    else passCnt++;
    tick();
    hif.MultStartE = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      totalCnt++;
      if (hif.stallF !== 1'b1) $display("FAIL mult_busy%0d got %b want 1", i, hif.stallF);
      else passCnt++;
      tick();
    end
    hif.MultDoneE = 1;
    @(negedge clk);
    totalCnt++;
    if (hif.stallD !== 1'b1) $display("FAIL mult_done_cycle got %b want 1", hif.stallD);
    else passCnt++;
    tick();
    hif.MultDoneE = 0;
    @(negedge clk);
    totalCnt++;
    if ({hif.stallF, hif.mult_err} !== 2'b00)
      $display("FAIL mult_after_done got %b want 00", {hif.stallF, hif.mult_err});
    else passCnt++;
    tick();
  endtask

  task automatic test_watchdog();
    clearIn();
    hif.WBSrcD = WB_MFLO; hif.MultStartE = 1;
    @(negedge clk);
    tick();
    hif.MultStartE = 0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      totalCnt++;
      if ({hif.stallF, hif.mult_err} !== 2'b10)
        $display("FAIL wd_busy%0d got %b want 10", i, {hif.stallF, hif.mult_err});
      else passCnt++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      totalCnt++;
      if ({hif.stallF, hif.mult_err} !== 2'b01)
        $display("FAIL wd_expired%0d got %b want 01", i, {hif.stallF, hif.mult_err});
      else passCnt++;
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    totalCnt++;
    if (hif.mult_err !== 1'b0) $display("FAIL wd_err_clear got %b want 0", hif.mult_err);
    else passCnt++;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    clearIn();
    hif.MultStartE = 1;
    tick();
    hif.MultStartE = 0; hif.WBSrcD = WB_MFHI;
    @(negedge clk);
    totalCnt++;
    if (hif.stallF !== 1'b1) $display("FAIL rmb_busy got %b want 1", hif.stallF);
    else passCnt++;
    tick();
    rst = 1;
    @(negedge clk);
    totalCnt++;
    if ({hif.stallF, hif.stallD, hif.flushE} !== 3'b001)
      $display("FAIL rmb_in_reset got %b want 001", {hif.stallF, hif.stallD, hif.flushE});
    else passCnt++;
    tick();
    rst = 0; hif.MultDoneE = 1;
    @(negedge clk);
    totalCnt++;
    if (hif.stallF !== 1'b0) $display("FAIL rmb_late_done got %b want 0", hif.stallF);
    else passCnt++;
    tick();
    hif.MultDoneE = 0;
    @(negedge clk);
    totalCnt++;
    if ({hif.stallF, hif.mult_err} !== 2'b00)
      $display("FAIL rmb_idle got %b want 00", {hif.stallF, hif.mult_err});
    else passCnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    clearIn();
    hif.WBSrcD = WB_MFHI; hif.MultStartE = 1;
    tick();
    hif.MultStartE = 0;
    tick();
    hif.MultStartE = 1; hif.MultDoneE = 1;
    tick();
    hif.MultStartE = 0; hif.MultDoneE = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      totalCnt++;
      if (hif.stallF !== 1'b1) $display("FAIL b2b_chained%0d got %b want 1", i, hif.stallF);
      else passCnt++;
      tick();
    end
    hif.MultDoneE = 1;
    tick();
    hif.MultDoneE = 0;
    @(negedge clk);
    totalCnt++;
    if ({hif.stallF, hif.mult_err} !== 2'b00)
      $display("FAIL b2b_end got %b want 00", {hif.stallF, hif.mult_err});
    else passCnt++;
    tick();
  endtask

  task automatic test_random();
    logic [9:0] exp;
    clearIn();
    for (int i = 0; i < 500; i++) begin
      randIn();
      rst = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      exp = expected();
      totalCnt++;
      if (observed() !== exp) $display("FAIL random%0d got %b want %b", i, observed(), exp);
      else passCnt++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward_priority();
    test_branch();
    test_mult();
    test_watchdog();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
